// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle chunked adder.
// Holds the controller state encoding and the chunk-index width calculation.
package adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } adder_state_t;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/fadd_chunk.sv
// Combinational CHUNK-bit ripple adder built from 1-bit full-adder cells.
// Also exposes the carry into its top bit so the caller can derive signed overflow.
module fadd_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i]   = a_c[i] ^ b_c[i] ^ c[i];
      c[i+1] = (a_c[i] & b_c[i]) | (c[i] & (a_c[i] ^ b_c[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder that resolves CHUNK bits per clock with a registered carry.
// Valid/ready on both sides; handshake outputs decode registered state only.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned NChunk = WIDTH / CHUNK;
  localparam int unsigned IdxW   = idx_width(NChunk);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);
  localparam logic [WIDTH-1:0] ChunkMask = WIDTH'({CHUNK{1'b1}});

  if (WIDTH < 2) begin : g_bad_width
    $error("chunked_adder: WIDTH must be at least 2");
  end
  if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
    $error("chunked_adder: CHUNK must divide WIDTH exactly");
  end

  adder_state_t    state_q;
  logic [IdxW-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic            carry_q, carry_out_q, overflow_q;

  logic [31:0]      off;
  logic [WIDTH-1:0] a_shift, b_shift, sum_next;
  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             chunk_cout, chunk_cmsb;

  // Bit offset of the chunk currently being resolved.
  assign off     = 32'(idx_q) * CHUNK;
  assign a_shift = a_q >> off;
  assign b_shift = b_q >> off;
  assign a_chunk = a_shift[CHUNK-1:0];
  assign b_chunk = b_shift[CHUNK-1:0];

  fadd_chunk #(
    .CHUNK (CHUNK)
  ) u_fadd_chunk (
    .a_c   (a_chunk),
    .b_c   (b_chunk),
    .cin   (carry_q),
    .s     (s_chunk),
    .cout  (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  // Merge the fresh chunk into the accumulated sum, leaving other chunks untouched.
  assign sum_next = (sum_q & ~(ChunkMask << off)) | (WIDTH'(s_chunk) << off);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= carry_in;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q   <= sum_next;
          carry_q <= chunk_cout;
          if (idx_q == LastIdx) begin
            carry_out_q <= chunk_cout;
            overflow_q  <= chunk_cmsb ^ chunk_cout;
            idx_q       <= '0;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule
